// File: rtl/uart_tx_async_if.sv
// Character/handshake bundle between the UART transmitter and its feeder
// (CPU holding-register writes or TX FIFO read port).
interface uart_tx_async_if;
  logic [7:0] tx_data;
  logic       write_tx_byte;
  logic       fifo_empty;
  logic       fifo_read;
  logic       tx_ready;
  logic       tx_idle;

  modport master (
    output tx_data, write_tx_byte, fifo_empty,
    input  fifo_read, tx_ready, tx_idle
  );

  modport slave (
    input  tx_data, write_tx_byte, fifo_empty,
    output fifo_read, tx_ready, tx_idle
  );
endinterface

// File: rtl/uart_tx_async.sv
// UART transmitter: 7/8 data bits, optional odd/even parity, one stop bit,
// each bit lasting 16 pulses of the 16x baud_clock enable.
module uart_tx_async #(
  parameter bit TX_FIFO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baud_clock,
  input  logic             bit8,
  input  logic             parity_en,
  input  logic             odd_n_even,
  uart_tx_async_if.slave   bus,
  output logic             tx
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] shift_q, shift_d;
  logic       hold_full_q, hold_full_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       fmt_bit8_q, fmt_bit8_d;
  logic       fmt_par_q, fmt_par_d;
  logic       fmt_odd_q, fmt_odd_d;
  logic       fifo_read_q, fifo_read_d;
  logic       rd_wait_q, rd_wait_d;
  logic       bit_end_s, last_bit_s, xfer_s, load_s;

  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

  // Bit timing and frame sequencing; xfer_s moves the held character to the shifter.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    fmt_bit8_d = fmt_bit8_q;
    fmt_par_d  = fmt_par_q;
    fmt_odd_d  = fmt_odd_q;
    last_bit_s = 1'b0;
    bit_end_s  = baud_clock & (cnt_q == 4'd15);
    xfer_s     = baud_clock & hold_full_q &
                 ((state_q == ST_IDLE) | ((state_q == ST_STOP) & (cnt_q == 4'd15)));
    if (state_q == ST_IDLE) begin
      cnt_d = 4'd0;
    end else if (baud_clock) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          shift_d    = hold_q;
          fmt_bit8_d = bit8;
          fmt_par_d  = parity_en;
          fmt_odd_d  = odd_n_even;
          parity_d   = 1'b0;
          bit_cnt_d  = 3'd0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          tx_d      = shift_q[0];
          parity_d  = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        last_bit_s = fmt_bit8_q ? (bit_cnt_q == 3'd7) : (bit_cnt_q == 3'd6);
        if (bit_end_s && last_bit_s && fmt_par_q) begin
          tx_d    = parity_bit(parity_q, fmt_odd_q);
          state_d = ST_PARITY;
        end else if (bit_end_s && last_bit_s) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else if (bit_end_s) begin
          tx_d      = shift_q[0];
          parity_d  = parity_q ^ shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (xfer_s) begin
          shift_d    = hold_q;
          fmt_bit8_d = bit8;
          fmt_par_d  = parity_en;
          fmt_odd_d  = odd_n_even;
          parity_d   = 1'b0;
          bit_cnt_d  = 3'd0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end else if (bit_end_s) begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register fill: a same-edge load wins over the transfer so no byte is lost.
  always_comb begin
    hold_d      = hold_q;
    fifo_read_d = 1'b0;
    rd_wait_d   = 1'b0;
    load_s      = 1'b0;
    if (TX_FIFO) begin
      fifo_read_d = ~hold_full_q & ~bus.fifo_empty & ~fifo_read_q & ~rd_wait_q;
      rd_wait_d   = fifo_read_q;
      load_s      = rd_wait_q;
    end else begin
      load_s = bus.write_tx_byte & (~hold_full_q | xfer_s);
    end
    if (load_s) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end else if (xfer_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // State register; reset drives the line idle and discards the held character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'h00;
      shift_q     <= 8'h00;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      fmt_bit8_q  <= 1'b0;
      fmt_par_q   <= 1'b0;
      fmt_odd_q   <= 1'b0;
      fifo_read_q <= 1'b0;
      rd_wait_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      fmt_bit8_q  <= fmt_bit8_d;
      fmt_par_q   <= fmt_par_d;
      fmt_odd_q   <= fmt_odd_d;
      fifo_read_q <= fifo_read_d;
      rd_wait_q   <= rd_wait_d;
    end
  end

  assign tx            = tx_q;
  assign bus.tx_ready  = ~hold_full_q;
  assign bus.tx_idle   = (state_q == ST_IDLE) & ~hold_full_q;
  assign bus.fifo_read = fifo_read_q;

endmodule

// File: tb/tb_uart_tx_async.sv
// Directed bench for uart_tx_async: frame table plus back-to-back, format
// latch, mid-frame reset and FIFO-fed sequences.
module tb_uart_tx_async;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_clock = 1'b0;
  logic bit8 = 1'b1;
  logic parity_en = 1'b0;
  logic odd_n_even = 1'b0;
  logic tx_d, tx_f;
  int   baud_div = 1;
  int   baud_cnt = 0;
  int   total = 0;
  int   bad = 0;

  uart_tx_async_if d_if ();
  uart_tx_async_if f_if ();

  logic [7:0] fifo_mem [0:3];
  logic [7:0] fifo_rdata;
  int rp, wp = 0;
  int rd_pulses = 0;
  int rd_consec = 0;
  logic fifo_read_prev = 1'b0;

  uart_tx_async #(.TX_FIFO(1'b0)) dut_d (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .bus(d_if), .tx(tx_d)
  );

  uart_tx_async #(.TX_FIFO(1'b1)) dut_f (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .bus(f_if), .tx(tx_f)
  );

  assign f_if.fifo_empty    = (rp == wp);
  assign f_if.tx_data       = fifo_rdata;
  assign f_if.write_tx_byte = 1'b0;

  initial forever #5 clk = ~clk;

  // Baud enable changes on the falling edge so it is stable at every rising edge.
  initial forever begin
    @(negedge clk);
    if (baud_cnt >= baud_div - 1) begin
      baud_cnt   = 0;
      baud_clock = 1'b1;
    end else begin
      baud_cnt   = baud_cnt + 1;
      baud_clock = 1'b0;
    end
  end

  // FIFO with registered read data, one clk after the pop.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rp         <= 0;
      fifo_rdata <= 8'h00;
    end else if (f_if.fifo_read) begin
      fifo_rdata <= fifo_mem[rp[1:0]];
      rp         <= rp + 1;
    end
  end

  always @(posedge clk) begin
    if (f_if.fifo_read) rd_pulses <= rd_pulses + 1;
    if (f_if.fifo_read && fifo_read_prev) rd_consec <= rd_consec + 1;
    fifo_read_prev <= f_if.fifo_read;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        b8;
    logic        pe;
    logic        odd;
    logic [7:0]  data;
    int          div;
    logic [10:0] frame;
    int          nbits;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx_f : tx_d;
  endfunction

  task automatic wait_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (baud_clock !== 1'b1);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    d_if.tx_data       = d;
    d_if.write_tx_byte = 1'b1;
    @(posedge clk);
    #1;
    d_if.write_tx_byte = 1'b0;
  endtask

  // Frame bits listed first-transmitted in bit 0; returns on the edge ending the stop bit.
  task automatic check_frame(input string name, input bit sel, input logic [10:0] frame,
                             input int nbits);
    int guard = 0;
    while (cur_tx(sel) !== 1'b0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_start_seen"}, 32'(guard < 400), 32'd1);
    if (guard >= 400) return;
    for (int i = 0; i < nbits; i++) begin
      wait_pulses(8);
      #1;
      check($sformatf("%s_bit%0d", name, i), 32'(cur_tx(sel)), 32'(frame[i]));
      wait_pulses(8);
    end
  endtask

  task automatic quiet_check(input string name, input bit sel, input int clks);
    int lows = 0;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      if (cur_tx(sel) !== 1'b1) lows++;
    end
    check(name, 32'(lows), 32'd0);
  endtask

  initial begin
    int guard;
    vec[0] = '{b8:1'b1, pe:1'b0, odd:1'b0, data:8'h55, div:1, frame:11'b01010101010, nbits:10};
    vec[1] = '{b8:1'b0, pe:1'b1, odd:1'b0, data:8'h41, div:1, frame:11'b01010000010, nbits:10};
    vec[2] = '{b8:1'b1, pe:1'b1, odd:1'b1, data:8'hFF, div:1, frame:11'b11111111110, nbits:11};
    vec[3] = '{b8:1'b0, pe:1'b0, odd:1'b0, data:8'h80, div:2, frame:11'b00100000000, nbits:9};
    vec[4] = '{b8:1'b1, pe:1'b1, odd:1'b0, data:8'h3C, div:1, frame:11'b10001111000, nbits:11};
    vec[5] = '{b8:1'b0, pe:1'b1, odd:1'b1, data:8'h03, div:3, frame:11'b01100000110, nbits:10};
    vec[6] = '{b8:1'b1, pe:1'b0, odd:1'b0, data:8'hA5, div:3, frame:11'b01101001010, nbits:10};
    fifo_mem[0] = 8'h12;
    fifo_mem[1] = 8'h34;
    fifo_mem[2] = 8'h00;
    fifo_mem[3] = 8'h00;
    d_if.tx_data       = 8'h00;
    d_if.write_tx_byte = 1'b0;
    d_if.fifo_empty    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx_d), 32'd1);
    check("rst_ready", 32'(d_if.tx_ready), 32'd1);
    check("rst_idle", 32'(d_if.tx_idle), 32'd1);
    check("rst_fifo_read", 32'(f_if.fifo_read), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) begin
      bit8       = vec[k].b8;
      parity_en  = vec[k].pe;
      odd_n_even = vec[k].odd;
      baud_div   = vec[k].div;
      repeat (4) @(posedge clk);
      #1;
      write_byte(vec[k].data);
      check($sformatf("v%0d_ready_low", k), 32'(d_if.tx_ready), 32'd0);
      check($sformatf("v%0d_idle_low", k), 32'(d_if.tx_idle), 32'd0);
      guard = 0;
      while (tx_d !== 1'b0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("v%0d_ready_at_start", k), 32'(d_if.tx_ready), 32'd1);
      check_frame($sformatf("v%0d", k), 1'b0, vec[k].frame, vec[k].nbits);
      #1;
      check($sformatf("v%0d_idle_end", k), 32'(d_if.tx_idle), 32'd1);
    end

    // Back-to-back frames; a third write while the holding register is full is dropped.
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; baud_div = 1;
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'hA5);
    fork
      check_frame("b2b_first", 1'b0, 11'b01101001010, 10);
      begin
        repeat (40) @(posedge clk);
        #1;
        write_byte(8'h3C);
        check("b2b_held", 32'(d_if.tx_ready), 32'd0);
        write_byte(8'h77);
        check("b2b_drop_still_full", 32'(d_if.tx_ready), 32'd0);
      end
    join
    #1;
    check("b2b_no_gap", 32'(tx_d), 32'd0);
    check_frame("b2b_second", 1'b0, 11'b01001111000, 10);
    #1;
    check("b2b_idle_end", 32'(d_if.tx_idle), 32'd1);
    quiet_check("b2b_dropped_not_sent", 1'b0, 60);

    // Write lands on the same edge as the hold-to-shift transfer.
    baud_div = 2;
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'h0F);
    do begin
      @(negedge clk);
      #1;
    end while (baud_clock !== 1'b1);
    d_if.tx_data       = 8'hF0;
    d_if.write_tx_byte = 1'b1;
    @(posedge clk);
    #1;
    d_if.write_tx_byte = 1'b0;
    check("simul_start", 32'(tx_d), 32'd0);
    check("simul_held", 32'(d_if.tx_ready), 32'd0);
    check_frame("simul_a", 1'b0, 11'b01000011110, 10);
    #1;
    check("simul_no_gap", 32'(tx_d), 32'd0);
    check_frame("simul_b", 1'b0, 11'b01111100000, 10);
    #1;
    check("simul_idle_end", 32'(d_if.tx_idle), 32'd1);

    // bit8 changed mid-frame only affects the following frame.
    baud_div = 1;
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'h00);
    fork
      check_frame("fmt_first", 1'b0, 11'b01000000000, 10);
      begin
        repeat (30) @(posedge clk);
        #1;
        bit8 = 1'b0;
      end
    join
    #1;
    check("fmt_first_len", 32'(d_if.tx_idle), 32'd1);
    write_byte(8'h80);
    check_frame("fmt_second", 1'b0, 11'b00100000000, 9);
    #1;
    check("fmt_second_len", 32'(d_if.tx_idle), 32'd1);

    // Asynchronous reset in the middle of data bit 4, with a character held.
    bit8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'h00);
    repeat (40) @(posedge clk);
    #1;
    write_byte(8'hAA);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx_d), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx_d), 32'd1);
    check("rst_mid_ready", 32'(d_if.tx_ready), 32'd1);
    check("rst_mid_idle", 32'(d_if.tx_idle), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    quiet_check("rst_no_frame", 1'b0, 200);
    check("rst_ready_after", 32'(d_if.tx_ready), 32'd1);

    // FIFO-fed instance: nothing while empty, then two contiguous frames.
    quiet_check("fifo_empty_quiet", 1'b1, 60);
    check("fifo_empty_no_read", 32'(rd_pulses), 32'd0);
    @(negedge clk);
    wp = 2;
    check_frame("fifo_a", 1'b1, 11'b01000100100, 10);
    #1;
    check("fifo_no_gap", 32'(tx_f), 32'd0);
    check_frame("fifo_b", 1'b1, 11'b01001101000, 10);
    #1;
    check("fifo_idle_end", 32'(f_if.tx_idle), 32'd1);
    check("fifo_read_count", 32'(rd_pulses), 32'd2);
    check("fifo_read_consec", 32'(rd_consec), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
